ifu2dec_buf: RTL and testbench
==============================

// Module: ifu2dec_buf
// PURPOSE
//  Registered decoupling FIFO between the fetch unit output (pc/instr/err/prdt_taken,
//  vld/rdy) and the decoder input. Breaks the combinational dec_rdy -> ifu/bpu/pc path.
//  Supports a single-cycle flush from the execute-stage jump.
//  Full throughput: one instruction per cycle, fixed 1-cycle latency.
// PARAMETERS
//  AW   32  PC width (MYRISCV_ADDRBUS)
//  IW   32  instruction width (MYRISCV_INSTBUS)
//  DP   2   entry count; power of two, >=2
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   asynchronous, active-low reset
//  flush_i           in   1   jump redirect; discard all entries and the current input
//  ifu_vld_i         in   1   fetch packet valid
//  ifu_rdy_o         out  1   buffer can accept
//  ifu_pc_i          in   AW  packet PC
//  ifu_instr_i       in   IW  packet instruction
//  ifu_err_i         in   1   fetch bus error
//  ifu_prdt_taken_i  in   1   BPU predicted-taken
//  dec_vld_o         out  1   head entry valid
//  dec_rdy_i         in   1   decoder accepts
//  dec_pc_o          out  AW  head PC
//  dec_instr_o       out  IW  head instruction
//  dec_err_o         out  1   head error
//  dec_prdt_taken_o  out  1   head prediction
//  occ_o             out  log2(DP)+1  entries held
// BEHAVIOUR
//  - Reset (rst=0, async): rptr=wptr=0, occ=0, dec_vld_o=0, ifu_rdy_o=1.
//    Payload regs are not reset; dec_* payload is don't-care while dec_vld_o=0.
//  - Storage: DP entries of {pc,instr,err,prdt_taken} (AW+IW+2 bits).
//    Pointers are log2(DP)+1 bits, wrap naturally.
//    full = ptr MSBs differ and LSBs equal; empty = ptrs equal.
//  - ifu_rdy_o = ~full | flush_i. It derives from registered state only, never from dec_rdy_i.
//  - Push when ifu_vld_i & ifu_rdy_o & ~flush_i: write entry at wptr, then wptr+1.
//  - dec_vld_o = ~empty & ~flush_i. dec_* is driven from entry[rptr], with no bypass.
//  - Pop when dec_vld_o & dec_rdy_i: rptr+1.
//  - Latency: a packet accepted in cycle N is presented to dec at cycle N+1 at the earliest.
//  - Simultaneous push and pop: occ unchanged. When full, a pop frees space at the next
//    cycle, not the same cycle, which keeps the decoder-ready path registered.
//    DP=2 still sustains 1/cycle.
//  - Flush (flush_i=1), highest priority:
//    - next cycle rptr=wptr=0, occ=0;
//    - the input packet in the flush cycle is consumed (rdy=1) and dropped;
//    - no pop is reported to dec (dec_vld_o=0).
//  - Flush together with a push and a pop in the same cycle: the flush wins and both are
//    ignored.
//  - Flush for multiple consecutive cycles keeps the buffer empty.
//  - occ_o = wptr - rptr, registered, range 0..DP.
//  - An asynchronous reset asserted mid-stream drops all entries immediately.
//    After deassertion the first push behaves as from empty.
//  - Handshake hold: while dec_vld_o=1 & dec_rdy_i=0 and there is no flush, dec_* stays
//    stable.
// TESTING
//  1 Reset: rst=0 with random inputs -> dec_vld_o=0, ifu_rdy_o=1, occ_o=0.
//    After release, drive one pkt pc=0x80000000, instr=0x00000013 ->
//    dec_vld_o=1 next cycle with the same values.
//  2 Streaming: 8 back-to-back pkts, pc 0x80000000+4k, with dec_rdy_i=1 ->
//    all 8 arrive in order at 1/cycle after 1 cycle of latency, and occ_o never exceeds 1.
//  3 Backpressure: dec_rdy_i=0, push pkts A, B -> occ_o=2, ifu_rdy_o=0, C held by the IFU.
//    Raise dec_rdy_i -> A, B, C delivered in order, none lost or duplicated.
//  4 Flush:
//    - setup: occ=2, flush_i=1 for 1 cycle while ifu_vld_i=1 with pc=0x80000100;
//    - during the flush cycle: dec_vld_o=0;
//    - next cycle: occ_o=0;
//    - then push pc=0x80000200 -> it is the next packet seen by dec.
//  5 Error/pred passthrough: pkt with err=1, prdt_taken=1, instr=0xFFFFFFFF ->
//    dec_err_o=1, dec_prdt_taken_o=1 with the same instr.
//    Pointer wrap after >=3*DP pushes keeps the order correct.
//  6 Mid-stream reset: assert rst=0 asynchronously between clock edges with occ=2 ->
//    dec_vld_o drops immediately and occ_o=0. No stale entry appears after release.

Source files
------------

// File: rtl/ifu2dec_buf.sv
// Registered decoupling FIFO between the fetch unit and the decoder.
// Ready toward the fetch unit comes from registered state only; a flush empties the buffer.
module ifu2dec_buf #(
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 32,
  parameter int unsigned DP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   ifu_vld_i,
  output logic                   ifu_rdy_o,
  input  logic [AW-1:0]          ifu_pc_i,
  input  logic [IW-1:0]          ifu_instr_i,
  input  logic                   ifu_err_i,
  input  logic                   ifu_prdt_taken_i,
  output logic                   dec_vld_o,
  input  logic                   dec_rdy_i,
  output logic [AW-1:0]          dec_pc_o,
  output logic [IW-1:0]          dec_instr_o,
  output logic                   dec_err_o,
  output logic                   dec_prdt_taken_o,
  output logic [$clog2(DP):0]    occ_o
);

  localparam int unsigned PW = $clog2(DP);
  localparam int unsigned EW = AW + IW + 2;
  localparam logic [PW:0] PtrInc = {{PW{1'b0}}, 1'b1};

  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;
  logic [EW-1:0] mem_q [DP];
  logic          full, empty, push, pop;

  // Extra pointer MSB tells full from empty when the index bits match.
  always_comb begin
    full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    empty = (wptr_q == rptr_q);
  end

  // A flush consumes the input packet, so ready is forced high during it.
  assign ifu_rdy_o = ~full | flush_i;
  assign dec_vld_o = ~empty & ~flush_i;
  assign push      = ifu_vld_i & ifu_rdy_o & ~flush_i;
  assign pop       = dec_vld_o & dec_rdy_i;
  assign occ_o     = wptr_q - rptr_q;

  assign {dec_pc_o, dec_instr_o, dec_err_o, dec_prdt_taken_o} = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrInc;
      if (pop)  rptr_d = rptr_q + PtrInc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Payload storage is not reset; it is only observed while dec_vld_o is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PW-1:0]] <= {ifu_pc_i, ifu_instr_i, ifu_err_i, ifu_prdt_taken_i};
    end
  end

endmodule

// File: tb/tb_ifu2dec_buf.sv
// Randomized and directed bench for ifu2dec_buf against a queue-based reference model.
module tb_ifu2dec_buf;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned DP = 2;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          err;
    logic          pt;
  } pkt_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush_i, ifu_vld_i, ifu_rdy_o, ifu_err_i, ifu_prdt_taken_i;
  logic [AW-1:0]        ifu_pc_i, dec_pc_o;
  logic [IW-1:0]        ifu_instr_i, dec_instr_o;
  logic                 dec_vld_o, dec_rdy_i, dec_err_o, dec_prdt_taken_o;
  logic [$clog2(DP):0]  occ_o;

  int   checks = 0;
  int   errors = 0;
  pkt_t model_q[$];
  logic last_acc;

  ifu2dec_buf #(.AW(AW), .IW(IW), .DP(DP)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .ifu_vld_i        (ifu_vld_i),
    .ifu_rdy_o        (ifu_rdy_o),
    .ifu_pc_i         (ifu_pc_i),
    .ifu_instr_i      (ifu_instr_i),
    .ifu_err_i        (ifu_err_i),
    .ifu_prdt_taken_i (ifu_prdt_taken_i),
    .dec_vld_o        (dec_vld_o),
    .dec_rdy_i        (dec_rdy_i),
    .dec_pc_o         (dec_pc_o),
    .dec_instr_o      (dec_instr_o),
    .dec_err_o        (dec_err_o),
    .dec_prdt_taken_o (dec_prdt_taken_o),
    .occ_o            (occ_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [AW-1:0] pc, input logic [IW-1:0] instr,
                                  input logic err, input logic pt);
    pkt_t p;
    p.pc = pc; p.instr = instr; p.err = err; p.pt = pt;
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    return mk_pkt($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endfunction

  // Called at posedge+1: drive, check at negedge, update the model at the next posedge.
  task automatic cycle(input logic flush, input logic vld, input logic rdy, input pkt_t p);
    logic exp_vld, exp_rdy;
    int   sz;
    pkt_t head;
    flush_i = flush; ifu_vld_i = vld; dec_rdy_i = rdy;
    ifu_pc_i = p.pc; ifu_instr_i = p.instr; ifu_err_i = p.err; ifu_prdt_taken_i = p.pt;
    sz      = model_q.size();
    exp_vld = (sz > 0) && !flush;
    exp_rdy = (sz < DP) || flush;
    @(negedge clk);
    check_eq("dec_vld", 64'(dec_vld_o), 64'(exp_vld));
    check_eq("ifu_rdy", 64'(ifu_rdy_o), 64'(exp_rdy));
    check_eq("occ", 64'(occ_o), 64'(sz));
    if (exp_vld && dec_vld_o) begin
      head = model_q[0];
      check_eq("dec_pc", 64'(dec_pc_o), 64'(head.pc));
      check_eq("dec_instr", 64'(dec_instr_o), 64'(head.instr));
      check_eq("dec_err", 64'(dec_err_o), 64'(head.err));
      check_eq("dec_pt", 64'(dec_prdt_taken_o), 64'(head.pt));
    end
    @(posedge clk);
    last_acc = vld && exp_rdy;
    if (flush) begin
      model_q.delete();
    end else begin
      if (exp_vld && rdy) void'(model_q.pop_front());
      if (vld && sz < DP) model_q.push_back(p);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, rdy, rand_pkt());
  endtask

  // Keep offering one packet until it is accepted, with a bounded cycle budget.
  task automatic send(input pkt_t p, input logic rdy);
    int n = 0;
    do begin
      cycle(1'b0, 1'b1, rdy, p);
      n++;
    end while (!last_acc && n < 20);
    check_eq("send_accepted", 64'(last_acc), 64'(1));
  endtask

  initial begin
    pkt_t cur;
    logic fl;
    rst = 1'b0;
    flush_i = 1'($urandom_range(1)); ifu_vld_i = 1'($urandom_range(1));
    dec_rdy_i = 1'($urandom_range(1)); ifu_pc_i = $urandom; ifu_instr_i = $urandom;
    ifu_err_i = 1'b0; ifu_prdt_taken_i = 1'b0;
    @(posedge clk); #3;
    check_eq("rst_vld", 64'(dec_vld_o), 64'(0));
    check_eq("rst_rdy", 64'(ifu_rdy_o), 64'(1));
    check_eq("rst_occ", 64'(occ_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Single packet after reset.
    cycle(1'b0, 1'b1, 1'b1, mk_pkt(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0));
    idle(1'b1);
    idle(1'b1);

    // Streaming 8 back-to-back packets.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, 1'b1, mk_pkt(32'h8000_0000 + 32'(4 * k), $urandom, 1'b0, 1'b0));
      check_eq("stream_occ_le1", 64'(occ_o <= 1), 64'(1));
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure: A, B fill the buffer, C waits.
    send(mk_pkt(32'hA, $urandom, 1'b0, 1'b0), 1'b0);
    send(mk_pkt(32'hB, $urandom, 1'b0, 1'b0), 1'b0);
    cycle(1'b0, 1'b1, 1'b0, mk_pkt(32'hC, 32'hCC, 1'b0, 1'b0));
    send(mk_pkt(32'hC, 32'hCC, 1'b0, 1'b0), 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Flush with occ=2 and an input packet that must be dropped.
    send(rand_pkt(), 1'b0);
    send(rand_pkt(), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, mk_pkt(32'h8000_0100, $urandom, 1'b0, 1'b0));
    idle(1'b0);
    send(mk_pkt(32'h8000_0200, $urandom, 1'b0, 1'b0), 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Error/prediction passthrough.
    send(mk_pkt($urandom, 32'hFFFF_FFFF, 1'b1, 1'b1), 1'b1);
    idle(1'b1);

    // Mid-stream asynchronous reset with occ=2.
    send(rand_pkt(), 1'b0);
    send(rand_pkt(), 1'b0);
    dec_rdy_i = 1'b0; ifu_vld_i = 1'b0; flush_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_vld", 64'(dec_vld_o), 64'(0));
    check_eq("arst_occ", 64'(occ_o), 64'(0));
    model_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1'b1);
    send(rand_pkt(), 1'b1);
    idle(1'b1);

    // Random traffic; the IFU holds a packet until it is taken or flushed.
    cur = rand_pkt();
    for (int i = 0; i < 2000; i++) begin
      fl = ($urandom_range(99) < 5);
      cycle(fl, 1'($urandom_range(99) < 70), 1'($urandom_range(99) < 60), cur);
      if (last_acc) cur = rand_pkt();
    end
    for (int k = 0; k < 4; k++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
